// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  function automatic logic fs_diff(input logic x, input logic y, input logic br);
    return x ^ y ^ br;
  endfunction

  function automatic logic fs_borrow(input logic x, input logic y, input logic br);
    return (~x & y) | (~(x ^ y) & br);
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] partial_q, partial_d;
  logic             br_q, br_d;
  logic             d_bit, b_next;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
`endif

  assign d_bit  = fs_diff(sa_q[0], sb_q[0], br_q);
  assign b_next = fs_borrow(sa_q[0], sb_q[0], br_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    diff_d    = diff_q;
    bout_d    = bout_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    partial_d = partial_q;
    br_d      = br_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d     = ovf_q;
    a_msb_d   = a_msb_q;
    b_msb_d   = b_msb_q;
`endif
    case (state_q)
      SHIFT: begin
        sa_d      = sa_q >> 1;
        sb_d      = sb_q >> 1;
        br_d      = b_next;
        partial_d = (partial_q >> 1) | {d_bit, {(WIDTH-1){1'b0}}};
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          diff_d  = partial_d;
          bout_d  = b_next;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
          state_d = DONE;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; DONE then allows back-to-back ops.
        if (start) begin
          sa_d      = a;
          sb_d      = b;
          br_d      = bin;
          cnt_d     = '0;
          partial_d = '0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d   = a[WIDTH-1];
          b_msb_d   = b[WIDTH-1];
`endif
          state_d   = SHIFT;
        end else begin
          state_d   = IDLE;
        end
      end
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Operand shift registers carry no control meaning and are always reloaded before use.
  always_ff @(posedge clk) begin
    sa_q      <= sa_d;
    sb_q      <= sb_d;
    partial_q <= partial_d;
    br_q      <= br_d;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_q   <= a_msb_d;
    b_msb_q   <= b_msb_d;
`endif
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
